dsp_chain_fir: RTL and testbench

DSP_CHAIN_FIR -- requirements
Module: dsp_chain_fir

---
 rtl/dsp_chain_fir.sv | 111 +++++++++++
 tb/tb_dsp_chain_fir.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_chain_fir.sv
// Systolic FIR filter with double-banked coefficients, a global clock enable,
// and saturated output. Coefficient commits wait for the pipeline to drain.
module dsp_chain_fir #(
  parameter int NUM_TAPS = 4,
  parameter int A_W      = 16,
  parameter int C_W      = 16,
  parameter int OUT_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic signed [A_W-1:0]        in_data,
  input  logic                         coef_wr,
  input  logic [$clog2(NUM_TAPS)-1:0]  coef_addr,
  input  logic signed [C_W-1:0]        coef_data,
  input  logic                         coef_commit,
  output logic                         out_valid,
  output logic signed [OUT_W-1:0]      out_data,
  output logic                         out_sat,
  output logic                         busy,
  output logic                         commit_pending
);

  localparam int AW    = $clog2(NUM_TAPS);
  localparam int P_W   = A_W + C_W;
  localparam int ACC_W = A_W + C_W + $clog2(NUM_TAPS);
  localparam int L     = NUM_TAPS + 2;
  localparam int DL    = 2 * NUM_TAPS - 1;
  localparam logic [AW:0] NT = (AW+1)'(NUM_TAPS);

  logic signed [C_W-1:0]   shadow     [NUM_TAPS];
  logic signed [C_W-1:0]   shadow_nxt [NUM_TAPS];
  logic signed [C_W-1:0]   active     [NUM_TAPS];
  logic signed [A_W-1:0]   xs         [DL];
  logic signed [P_W-1:0]   prod       [NUM_TAPS];
  logic signed [ACC_W-1:0] psum       [NUM_TAPS];
  logic [L-1:0]            vpipe;
  logic                    accept;
  logic                    do_copy;
  logic signed [OUT_W-1:0] sat_data;
  logic                    sat_flag;

  // A pending commit blocks new samples so the pipeline can drain.
  assign accept  = in_valid & ~commit_pending;
  assign busy    = ~rst & (accept | (|vpipe));
  assign do_copy = (coef_commit | commit_pending) & ~busy;

  // NOTE: every signal written in always_comb gets a full default first so no latch is inferred.
  always_comb begin
    shadow_nxt = shadow;
    if (coef_wr && ({1'b0, coef_addr} < NT)) shadow_nxt[coef_addr] = coef_data;
  end

  // NOTE: the coefficient banks are small register files, so they are reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      commit_pending <= 1'b0;
    end else if (ce) begin
      shadow <= shadow_nxt;
      if (do_copy) active <= shadow_nxt;
      if (do_copy)          commit_pending <= 1'b0;
      else if (coef_commit) commit_pending <= 1'b1;
    end
  end

  // Tap k multiplies the sample delayed 2k, matching the one-step skew of the psum chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DL; i++) xs[i] <= '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        prod[k] <= '0;
        psum[k] <= '0;
      end
      vpipe     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (ce) begin
      xs[0] <= accept ? in_data : '0;
      for (int i = 1; i < DL; i++) xs[i] <= xs[i-1];
      vpipe <= {vpipe[L-2:0], accept};
      for (int k = 0; k < NUM_TAPS; k++) prod[k] <= P_W'(xs[2*k]) * P_W'(active[k]);
      psum[0] <= ACC_W'(prod[0]);
      for (int k = 1; k < NUM_TAPS; k++) psum[k] <= psum[k-1] + ACC_W'(prod[k]);
      out_valid <= vpipe[L-1];
      out_data  <= sat_data;
      out_sat   <= sat_flag;
    end
  end

  generate
    if (ACC_W > OUT_W) begin : g_clip
      // In range only when every bit above the output sign bit equals it.
      logic [ACC_W-OUT_W:0] top;
      assign top      = psum[NUM_TAPS-1][ACC_W-1:OUT_W-1];
      assign sat_flag = ~((&top) | ~(|top));
      assign sat_data = !sat_flag ? psum[NUM_TAPS-1][OUT_W-1:0] :
                        psum[NUM_TAPS-1][ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                                    {1'b0, {(OUT_W-1){1'b1}}};
    end else begin : g_ext
      assign sat_data = OUT_W'(psum[NUM_TAPS-1]);
      assign sat_flag = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_dsp_chain_fir.sv
// Scoreboard bench for dsp_chain_fir: a behavioural FIR model predicts each
// result and its due enabled-cycle; a monitor checks every presented output.
module tb_dsp_chain_fir;
  localparam int N     = 4;
  localparam int OUT_W = 32;
  localparam int L     = N + 2;

  logic clk, rst, ce, in_valid, coef_wr, coef_commit;
  logic signed [15:0] in_data, coef_data;
  logic [1:0] coef_addr;
  logic out_valid, out_sat, busy, commit_pending;
  logic signed [31:0] out_data;

  dsp_chain_fir #(.NUM_TAPS(N), .A_W(16), .C_W(16), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_data(in_data),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_commit(coef_commit), .out_valid(out_valid), .out_data(out_data),
    .out_sat(out_sat), .busy(busy), .commit_pending(commit_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { longint data; bit sat; int due; } exp_t;

  int n_checks = 0;
  int n_errors = 0;

  longint act_m [N];
  longint sh_m  [N];
  longint hist  [$];
  bit     vhist [$];
  bit     m_pending;
  int     m_edges = 0;
  int     mon_edges = 0;
  exp_t   expq [$];
  longint obs_data [$];
  bit     obs_sat  [$];

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  function automatic bit in_flight();
    foreach (vhist[i]) if (vhist[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      act_m[k] = 0;
      sh_m[k]  = 0;
    end
    hist.delete();
    vhist.delete();
    repeat (N) hist.push_back(0);
    repeat (L) vhist.push_back(1'b0);
    m_pending = 1'b0;
    expq.delete();
  endtask

  task automatic clip(input longint y, output longint d, output bit s);
    longint mx, mn;
    mx = (longint'(1) <<< (OUT_W-1)) - 1;
    mn = -(longint'(1) <<< (OUT_W-1));
    s = (y > mx) || (y < mn);
    d = (y > mx) ? mx : (y < mn) ? mn : y;
  endtask

  // One enabled edge of the filter, stated as y[n] = sum c_k * x[n-k].
  task automatic model_edge(input bit v, input int d, input bit wr, input int a, input int cd, input bit cm);
    bit accept, bsy, ys;
    longint y, yd;
    exp_t e;
    accept = v && !m_pending;
    bsy = accept || in_flight();
    if (wr) sh_m[a] = cd;
    if ((cm || m_pending) && !bsy) begin
      act_m = sh_m;
      m_pending = 1'b0;
    end else if (cm) begin
      m_pending = 1'b1;
    end
    hist.push_front(accept ? longint'(d) : longint'(0));
    void'(hist.pop_back());
    vhist.push_front(accept);
    void'(vhist.pop_back());
    m_edges++;
    if (accept) begin
      y = 0;
      for (int k = 0; k < N; k++) y += act_m[k] * hist[k];
      clip(y, yd, ys);
      e.data = yd;
      e.sat = ys;
      e.due = m_edges + L;
      expq.push_back(e);
    end
  endtask

  task automatic drive(input bit c, input bit v, input int d, input bit wr, input int a, input int cd, input bit cm);
    ce = c;
    in_valid = v;
    in_data = d[15:0];
    coef_wr = wr;
    coef_addr = a[1:0];
    coef_data = cd[15:0];
    coef_commit = cm;
    #1;
    check("busy", busy, (v && !m_pending) || in_flight());
    check("commit_pending", commit_pending, m_pending);
    if (c) model_edge(v, d, wr, a, cd, cm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (expq.size() > 0 && guard < 200) begin
      idle();
      guard++;
    end
    check("drain_timeout", expq.size(), 0);
  endtask

  task automatic load_coefs();
    for (int k = 0; k < N; k++) drive(1'b1, 1'b0, 0, 1'b1, k, rnd16(), k == N-1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_sat"}, out_sat, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_commit_pending"}, commit_pending, 0);
  endtask

  always @(posedge clk) begin : monitor
    bit en;
    exp_t e;
    en = ce && !rst;
    #1;
    if (en) begin
      mon_edges++;
      if (out_valid === 1'b1) begin
        obs_data.push_back(out_data);
        obs_sat.push_back(out_sat);
        if (expq.size() == 0) begin
          check("spurious_out_valid", out_valid, 0);
        end else begin
          e = expq.pop_front();
          check("out_data", out_data, e.data);
          check("out_sat", out_sat, e.sat);
          check("latency", mon_edges, e.due);
        end
      end else if (expq.size() > 0 && expq[0].due <= mon_edges) begin
        check("out_valid_missing", out_valid, 1);
        e = expq.pop_front();
      end
    end
  end

  initial begin
    longint imp_exp [4];
    longint sat_exp [4];
    bit     satf_exp [4];
    int base;
    imp_exp  = '{1, 2, 3, 4};
    sat_exp  = '{64'sd1073741824, 64'sd2147483647, 64'sd2147483647, 64'sd2147483647};
    satf_exp = '{1'b0, 1'b1, 1'b1, 1'b1};

    rst = 1'b1; ce = 1'b1; in_valid = 1'b0; in_data = '0;
    coef_wr = 1'b0; coef_addr = '0; coef_data = '0; coef_commit = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset_ce1");
    ce = 1'b0;
    #10;
    check_reset_outputs("reset_ce0");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Impulse through coefficients 1..4, committed in the same cycle as the last write.
    base = obs_data.size();
    for (int k = 0; k < N; k++) drive(1'b1, 1'b0, 0, 1'b1, k, k + 1, k == N-1);
    drive(1'b1, 1'b1, 1, 1'b0, 0, 0, 1'b0);
    repeat (3) drive(1'b1, 1'b1, 0, 1'b0, 0, 0, 1'b0);
    drain();
    check("impulse_count", obs_data.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < obs_data.size()) check("impulse_value", obs_data[base+i], imp_exp[i]);

    // Worst-case magnitude: every product is 2^30.
    base = obs_data.size();
    for (int k = 0; k < N; k++) drive(1'b1, 1'b0, 0, 1'b1, k, -32768, k == N-1);
    repeat (4) drive(1'b1, 1'b1, -32768, 1'b0, 0, 0, 1'b0);
    drain();
    check("sat_count", obs_data.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < obs_data.size()) begin
        check("sat_value", obs_data[base+i], sat_exp[i]);
        check("sat_flag", obs_sat[base+i], satf_exp[i]);
      end

    // Random stream at full rate.
    load_coefs();
    repeat (40) drive(1'b1, ($urandom % 4) != 0, rnd16(), 1'b0, 0, 0, 1'b0);
    drain();

    // Random clock-enable stalls with stray writes and commits.
    repeat (120) drive(($urandom % 3) != 0, ($urandom % 2) == 1, rnd16(),
                       ($urandom % 6) == 0, int'($urandom % 4), rnd16(), ($urandom % 20) == 0);
    drain();

    // Commit while busy: further commits absorbed, samples ignored until drained.
    for (int i = 0; i < 24; i++)
      drive(1'b1, 1'b1, rnd16(), (i < 4) || (i == 12), i % 4, rnd16(), (i == 6) || (i == 9));
    drain();

    // Alternating valid/invalid stream.
    load_coefs();
    for (int i = 0; i < 20; i++) drive(1'b1, (i % 2) == 0, rnd16(), 1'b0, 0, 0, 1'b0);
    drain();

    // Reset with three samples in flight and a commit pending.
    load_coefs();
    drive(1'b1, 1'b1, rnd16(), 1'b0, 0, 0, 1'b0);
    drive(1'b1, 1'b1, rnd16(), 1'b0, 0, 0, 1'b0);
    drive(1'b1, 1'b1, rnd16(), 1'b0, 0, 0, 1'b1);
    check("pending_before_reset", commit_pending, m_pending);
    in_valid = 1'b0;
    coef_commit = 1'b0;
    coef_wr = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midstream_reset");
    ce = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #4;
    rst = 1'b0;
    @(posedge clk);
    #1;
    base = obs_data.size();
    drive(1'b1, 1'b1, 1, 1'b0, 0, 0, 1'b0);
    repeat (3) drive(1'b1, 1'b1, 0, 1'b0, 0, 0, 1'b0);
    drain();
    check("post_reset_count", obs_data.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (base + i < obs_data.size()) check("post_reset_coef_zero", obs_data[base+i], 0);
    repeat (L + 2) idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
